// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer wrapped around one external 1-bit full adder, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_ci,
  input  logic         fa_sum,
  input  logic         fa_co,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   areg_q, areg_d, breg_q, breg_d, sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d, cout_q, cout_d, done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    // done is registered so the pulse lands one edge after the DONE state
    done_d  = (state_q == DONE);
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          areg_d  = a;
          breg_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // adder outputs are only consumed here, so garbage outside SHIFT never lands
        sum_d   = {fa_sum, sum_q[N-1:1]};
        areg_d  = areg_q >> 1;
        breg_d  = breg_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) begin
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == SHIFT);
  assign fa_a  = areg_q[0] & busy;
  assign fa_b  = breg_q[0] & busy;
  assign fa_ci = carry_q & busy;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: behavioural adder + age-based reference model, per-cycle compare.
module tb_serial_add_ctrl;
  localparam int N = 8;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic         fa_a, fa_b, fa_ci, fa_sum, fa_co, busy, done, cout;
  logic [N-1:0] sum;
  logic         noise_s = 1'b0, noise_c = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0, failures = 0;

  serial_add_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .fa_a(fa_a), .fa_b(fa_b), .fa_ci(fa_ci), .fa_sum(fa_sum), .fa_co(fa_co),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;

  // Full adder; outside SHIFT its outputs carry random junk that must be ignored
  assign fa_sum = busy ? (fa_a ^ fa_b ^ fa_ci) : noise_s;
  assign fa_co  = busy ? ((fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci)) : noise_c;
  always @(negedge clk) begin
    noise_s <= 1'($urandom);
    noise_c <= 1'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: age = edges since the accepting edge (-1 = nothing since reset)
  int           m_age;
  logic [N-1:0] m_a, m_b;
  logic         m_c, m_ovf;
  logic [N:0]   m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age <= -1; m_a <= '0; m_b <= '0; m_c <= 1'b0; m_res <= '0; m_ovf <= 1'b0;
    end else if (start && (m_age < 0 || m_age >= N + 1)) begin
      m_age <= 0; m_a <= a; m_b <= b; m_c <= cin;
      m_res <= {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      m_ovf <= signed_ovf(a, b, cin);
    end else if (m_age >= 0 && m_age < N + 2) begin
      m_age <= m_age + 1;
    end
  end

  function automatic logic signed_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N-1:0] s;
    s = x + y + N'(c);
    return (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
  endfunction

  function automatic logic carry_into(input int j);
    logic [63:0] mk, t;
    mk = (64'd1 << j) - 64'd1;
    t  = (64'(m_a) & mk) + (64'(m_b) & mk) + 64'(m_c);
    return t[j];
  endfunction

  always @(negedge clk) begin
    logic eb;
    eb = (m_age >= 0 && m_age < N);
    chk("cyc_busy", 64'(busy), 64'(eb));
    chk("cyc_done", 64'(done), 64'(m_age == N + 1));
    if (eb) begin
      chk("cyc_fa_a", 64'(fa_a), 64'(m_a[m_age]));
      chk("cyc_fa_b", 64'(fa_b), 64'(m_b[m_age]));
      chk("cyc_fa_ci", 64'(fa_ci), 64'(carry_into(m_age)));
    end else begin
      chk("cyc_fa_idle", 64'({fa_a, fa_b, fa_ci}), 64'd0);
    end
    if (m_age < 0 || m_age >= N) begin
      chk("cyc_result", 64'({cout, sum}), 64'(m_res));
`ifdef SERIAL_ADD_OVF_EN
      chk("cyc_ovf", 64'(ovf), 64'(m_ovf));
`endif
    end
  end

  // From the negedge just after the accepting edge, wait (bounded) for done
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_add(input logic [N-1:0] ta, input logic [N-1:0] tb2, input logic tc,
                        output int lat, output int busy_n);
    a = ta; b = tb2; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
    wait_done(lat, busy_n);
  endtask

  initial begin
    int lat, bn;
    logic [N-1:0] ra, rb;
    logic rc;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    chk("reset_busy_done", 64'({busy, done}), 64'd0);

    // 1
    do_add(8'h0F, 8'h01, 1'b0, lat, bn);
    chk("t1_busy_cycles", 64'(bn), 64'd8);
    chk("t1_latency", 64'(lat), 64'(N + 1));
    chk("t1_sum", 64'(sum), 64'h10);
    chk("t1_cout", 64'(cout), 64'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", 64'(done), 64'd0);

    // 2
    do_add(8'hFF, 8'h01, 1'b0, lat, bn);
    chk("t2a_result", 64'({cout, sum}), 64'h100);
    do_add(8'h00, 8'h00, 1'b1, lat, bn);
    chk("t2b_result", 64'({cout, sum}), 64'h001);

    // 3: start held through SHIFT and DONE
    a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    wait_done(lat, bn);
    chk("t3_latency", 64'(lat), 64'(N + 1));
    chk("t3_result", 64'({cout, sum}), 64'h0FF);
    a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t3_restart_busy", 64'(busy), 64'd1);
    wait_done(lat, bn);
    chk("t3_second_result", 64'({cout, sum}), 64'h046);

    // 4: async reset after 4 SHIFT edges
    a = 8'hC3; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t4_reset_outputs", 64'({busy, done, cout, sum, fa_a, fa_b, fa_ci}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_add(8'h80, 8'h80, 1'b0, lat, bn);
    chk("t4_after_reset", 64'({cout, sum}), 64'h100);

`ifdef SERIAL_ADD_OVF_EN
    // 6
    do_add(8'h7F, 8'h01, 1'b0, lat, bn);
    chk("t6a_sum", 64'(sum), 64'h80);
    chk("t6a_ovf", 64'(ovf), 64'd1);
    do_add(8'hFF, 8'h01, 1'b0, lat, bn);
    chk("t6b_ovf", 64'(ovf), 64'd0);
    do_add(8'h80, 8'h80, 1'b0, lat, bn);
    chk("t6c_ovf_cout", 64'({ovf, cout}), 64'h3);
`endif

    // 5: random
    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom); rb = N'($urandom); rc = 1'($urandom);
      do_add(ra, rb, rc, lat, bn);
      chk("t5_latency", 64'(lat), 64'(N + 1));
      chk("t5_result", 64'({cout, sum}), 64'({1'b0, ra} + {1'b0, rb} + (N+1)'(rc)));
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
